b_cond_decode: RTL and testbench

//  Evaluates the AArch64 B.cond condition for the single-cycle CPU.

---
 rtl/b_cond_decode_if.sv | 23 ++
 rtl/b_cond_decode.sv | 63 ++++++
 tb/tb_b_cond_decode.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/b_cond_decode_if.sv
// Signal bundle between the instruction decoder and the B.cond evaluator.
// The master drives the instruction and ALU flag inputs; the slave returns branch and flags.
interface b_cond_decode_if;
   logic       cond;
   logic       update;
   logic       negative;
   logic       zero;
   logic       carry;
   logic       overflow;
   logic [4:0] Rd;
   logic       branch;
   logic [3:0] flags;

   modport master (
      output cond, update, negative, zero, carry, overflow, Rd,
      input  branch, flags
   );

   modport slave (
      input  cond, update, negative, zero, carry, overflow, Rd,
      output branch, flags
   );
endinterface

// File: rtl/b_cond_decode.sv
// AArch64 B.cond evaluator holding the architectural NZCV register.
// Optional macro FLAG_FORWARD_EN: evaluate against incoming ALU flags when update is high.
module b_cond_decode (
   input logic           clk,
   input logic           reset,
   b_cond_decode_if.slave bus
);

   logic [3:0] flags_q;
   logic [3:0] flags_in;
   logic [3:0] eval_flags;
   logic       n_f, z_f, c_f, v_f;
   logic       holds;
   logic       unused_rd;

   assign flags_in  = {bus.negative, bus.zero, bus.carry, bus.overflow};
   // Bit 4 of the Rd field carries no meaning for B.cond.
   assign unused_rd = bus.Rd[4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= 4'b0000;
      end else if (bus.update) begin
         flags_q <= flags_in;
      end
   end

`ifdef FLAG_FORWARD_EN
   assign eval_flags = bus.update ? flags_in : flags_q;
`else
   assign eval_flags = flags_q;
`endif

   assign {n_f, z_f, c_f, v_f} = eval_flags;

   always_comb begin
      holds = 1'b0;
      case (bus.Rd[3:0])
         4'h0:    holds = z_f;
         4'h1:    holds = !z_f;
         4'h2:    holds = c_f;
         4'h3:    holds = !c_f;
         4'h4:    holds = n_f;
         4'h5:    holds = !n_f;
         4'h6:    holds = v_f;
         4'h7:    holds = !v_f;
         4'h8:    holds = c_f & !z_f;
         4'h9:    holds = !(c_f & !z_f);
         4'hA:    holds = (n_f == v_f);
         4'hB:    holds = (n_f != v_f);
         4'hC:    holds = !z_f & (n_f == v_f);
         4'hD:    holds = !(!z_f & (n_f == v_f));
         4'hE:    holds = 1'b1;
         4'hF:    holds = 1'b1;
         default: holds = 1'b0;
      endcase
   end

   // AND-gating keeps branch low when cond is low even if Rd is unknown.
   assign bus.branch = bus.cond & holds;
   assign bus.flags  = flags_q;

endmodule

// File: tb/tb_b_cond_decode.sv
// Scoreboard bench for b_cond_decode: directed cases plus random stimulus vs. a condition model.
module tb_b_cond_decode;

   logic clk;
   logic reset;
   b_cond_decode_if bus ();

   b_cond_decode dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       br;
      logic [3:0] fl;
      string      nm;
   } exp_t;

   exp_t       exp_q[$];
   event       chk_ev;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [3:0] ref_flags;

   // ARM ConditionHolds: pick a base test from code[3:1], invert on code[0] except for NV.
   function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v, r;
      {n, z, c, v} = f;
      case (code[3:1])
         3'd0: r = z;
         3'd1: r = c;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = c && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (code[0] && code != 4'hF) r = !r;
      return r;
   endfunction

   task automatic apply(input logic c, input logic u, input logic [3:0] nzcv,
                        input logic [4:0] rd);
      bus.cond = c;
      bus.update = u;
      {bus.negative, bus.zero, bus.carry, bus.overflow} = nzcv;
      bus.Rd = rd;
   endtask

   task automatic check(input string nm);
      exp_t       e;
      logic [3:0] use_f;
      use_f = ref_flags;
`ifdef FLAG_FORWARD_EN
      if (bus.update) use_f = {bus.negative, bus.zero, bus.carry, bus.overflow};
`endif
      e.br = bus.cond && cond_holds(bus.Rd[3:0], use_f);
      e.fl = ref_flags;
      e.nm = nm;
      exp_q.push_back(e);
      #1;
      ->chk_ev;
      #1;
   endtask

   // Advance one cycle; the model latches flags on the edge if update is high.
   task automatic tick();
      @(posedge clk);
      if (!reset && bus.update)
         ref_flags = {bus.negative, bus.zero, bus.carry, bus.overflow};
      @(negedge clk);
   endtask

   task automatic load(input logic [3:0] nzcv);
      apply(1'b0, 1'b1, nzcv, 5'd0);
      tick();
      apply(1'b0, 1'b0, 4'b0000, 5'd0);
   endtask

   always @(chk_ev) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL monitor: output seen with empty scoreboard");
      end else begin
         e = exp_q.pop_front();
         n_tests++;
         if (bus.branch !== e.br || bus.flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s: branch=%0b flags=%04b, expected branch=%0b flags=%04b",
                     e.nm, bus.branch, bus.flags, e.br, e.fl);
         end
      end
   end

   initial begin
      logic [3:0] rnd;
      reset = 1'b1;
      ref_flags = 4'b0000;
      apply(1'b0, 1'b0, 4'b0000, 5'd0);
      #2;
      check("reset_flags");
      apply(1'b1, 1'b0, 4'b0000, 5'h01);
      check("reset_ne");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      apply(1'b0, 1'b0, 4'b0000, 5'd0);
      check("post_reset_flags");
      apply(1'b1, 1'b0, 4'b0000, 5'h00);
      check("eq_clear");
      apply(1'b1, 1'b0, 4'b0000, 5'h01);
      check("ne_clear");

      load(4'b0100);
      check("load_z");
      apply(1'b1, 1'b0, 4'b0000, 5'h00);
      check("eq_zset");
      apply(1'b1, 1'b0, 4'b0000, 5'h08);
      check("hi_zset");

      load(4'b1000);
      apply(1'b1, 1'b0, 4'b0000, 5'h0B);
      check("lt_n");
      apply(1'b1, 1'b0, 4'b0000, 5'h0A);
      check("ge_n");
      apply(1'b1, 1'b0, 4'b0000, 5'h0D);
      check("le_n");
      apply(1'b0, 1'b0, 4'b0000, 5'h0D);
      check("cond_off");

      load(4'b0010);
      apply(1'b1, 1'b0, 4'b0000, 5'h02);
      check("hs_c");
      apply(1'b1, 1'b0, 4'b0000, 5'h08);
      check("hi_c");
      apply(1'b1, 1'b0, 4'b0000, 5'h09);
      check("ls_c");
      apply(1'b1, 1'b0, 4'b0000, 5'h1E);
      check("al_bit4");
      apply(1'b1, 1'b0, 4'b0000, 5'h1F);
      check("nv_bit4");

      load(4'b1011);
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 1'b0, 4'($urandom), 5'($urandom));
         tick();
         check("hold");
      end
      apply(1'b0, 1'b0, 4'b0000, 5'bxxxxx);
      check("x_rd_cond_off");

      // Reset asserted away from any clock edge must clear flags at once.
      #2;
      reset = 1'b1;
      ref_flags = 4'b0000;
      check("async_reset");
      apply(1'b1, 1'b1, 4'b1111, 5'h01);
      check("ne_in_reset");
      tick();
      check("reset_blocks_update");
      reset = 1'b0;
      apply(1'b0, 1'b0, 4'b0000, 5'd0);

      load(4'b0000);
      apply(1'b1, 1'b1, 4'b0100, 5'h00);
      check("simul_cond_update");
      tick();
      apply(1'b0, 1'b0, 4'b0000, 5'd0);
      check("simul_loaded");

      for (int i = 0; i < 300; i++) begin
         rnd = 4'($urandom);
         apply(1'($urandom), 1'($urandom_range(0, 2) == 0), rnd, 5'($urandom));
         check("random");
         tick();
      end

      #5;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
